mul_sequencer: RTL and testbench

//  Multi-cycle controller for the HI/LO multiply unit: sequences an iterative radix-2 shift-add multiplier,

---
 rtl/mul_pkg.sv | 78 +++++++
 rtl/mul_shift_add.sv | 50 +++++
 rtl/mul_sequencer.sv | 147 ++++++++++++++
 tb/tb_mul_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types, function codes and decode helpers for the HI/LO multiply sequencer.
package mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFinish
  } mul_state_t;

  typedef enum logic [3:0] {
    OpNone,
    OpMult,
    OpMultu,
    OpMadd,
    OpMaddu,
    OpMsub,
    OpMsubu,
    OpMul,
    OpMthi,
    OpMtlo,
    OpMfhi,
    OpMflo
  } mul_op_t;

  // SPECIAL function codes
  localparam logic [5:0] FuncMfhi   = 6'h10;
  localparam logic [5:0] FuncMthi   = 6'h11;
  localparam logic [5:0] FuncMflo   = 6'h12;
  localparam logic [5:0] FuncMtlo   = 6'h13;
  localparam logic [5:0] FuncMult   = 6'h18;
  localparam logic [5:0] FuncMultu  = 6'h19;
  // SPECIAL2 function codes
  localparam logic [5:0] Func2Madd  = 6'h00;
  localparam logic [5:0] Func2Maddu = 6'h01;
  localparam logic [5:0] Func2Mul   = 6'h02;
  localparam logic [5:0] Func2Msub  = 6'h04;
  localparam logic [5:0] Func2Msubu = 6'h05;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic mul_op_t decode_op(input logic sp2, input logic [5:0] func);
    mul_op_t op;
    op = OpNone;
    if (sp2) begin
      case (func)
        Func2Madd:  op = OpMadd;
        Func2Maddu: op = OpMaddu;
        Func2Mul:   op = OpMul;
        Func2Msub:  op = OpMsub;
        Func2Msubu: op = OpMsubu;
        default:    op = OpNone;
      endcase
    end else begin
      case (func)
        FuncMfhi:  op = OpMfhi;
        FuncMthi:  op = OpMthi;
        FuncMflo:  op = OpMflo;
        FuncMtlo:  op = OpMtlo;
        FuncMult:  op = OpMult;
        FuncMultu: op = OpMultu;
        default:   op = OpNone;
      endcase
    end
    return op;
  endfunction

  function automatic logic is_long_op(input mul_op_t op);
    return (op == OpMult) || (op == OpMultu) || (op == OpMadd) || (op == OpMaddu) ||
           (op == OpMsub) || (op == OpMsubu) || (op == OpMul);
  endfunction

  function automatic logic is_signed_op(input mul_op_t op);
    return (op == OpMult) || (op == OpMadd) || (op == OpMsub) || (op == OpMul);
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Radix-2 shift-add datapath: one multiplier bit per step, LSB first, on unsigned magnitudes.
module mul_shift_add #(
  parameter int unsigned Width = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [Width-1:0]   mcand_i,
  input  logic [Width-1:0]   mplier_i,
  output logic [2*Width-1:0] acc_o,
  output logic               done_zero_o
);

  logic [2*Width-1:0] acc_q, acc_d;
  logic [2*Width-1:0] mcand_q, mcand_d;
  logic [Width-1:0]   mplier_q, mplier_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{Width{1'b0}}, mcand_i};
      mplier_d = mplier_i;
    end else if (step_i) begin
      acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign acc_o = acc_q;
  // True when the bit consumed by the current step is the last non-zero one.
  assign done_zero_o = (mplier_q[Width-1:1] == '0);

endmodule

// File: rtl/mul_sequencer.sv
// HI/LO multiply sequencer: FSM, HI/LO ownership and stall control around mul_shift_add.
// Optional MUL_EARLY_TERM_EN ends CALC once the remaining multiplier bits are all zero.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Start,
  input  logic             Sp2,
  input  logic [5:0]       Func,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             ResultWrite,
  output logic [WIDTH-1:0] MulResult,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  mul_state_t         state_q, state_d;
  mul_op_t            op_q, op_d;
  logic               neg_q, neg_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   mul_result_q, mul_result_d;
  logic               done_q, done_d, rw_q, rw_d;

  mul_op_t            dec_op;
  logic               accept, load, step, last_step, done_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc, p_fin;

  assign dec_op = decode_op(Sp2, Func);
  assign accept = Start && (state_q == StIdle);
  assign load   = accept && is_long_op(dec_op);
  assign step   = (state_q == StCalc);
  assign a_mag  = (is_signed_op(dec_op) && A[WIDTH-1]) ? -A : A;
  assign b_mag  = (is_signed_op(dec_op) && B[WIDTH-1]) ? -B : B;

`ifdef MUL_EARLY_TERM_EN
  assign last_step = (cnt_q == CntW'(WIDTH - 1)) || done_zero;
`else
  logic unused_done_zero;
  assign unused_done_zero = done_zero;
  assign last_step = (cnt_q == CntW'(WIDTH - 1));
`endif

  mul_shift_add #(
    .Width(WIDTH)
  ) u_shift_add (
    .clk_i      (Clock),
    .rst_ni     (nReset),
    .load_i     (load),
    .step_i     (step),
    .mcand_i    (a_mag),
    .mplier_i   (b_mag),
    .acc_o      (acc),
    .done_zero_o(done_zero)
  );

  assign p_fin = neg_q ? -acc : acc;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    neg_d        = neg_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_result_d = mul_result_q;
    done_d       = 1'b0;
    rw_d         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StCalc;
          op_d    = dec_op;
          neg_d   = is_signed_op(dec_op) && (A[WIDTH-1] ^ B[WIDTH-1]);
          cnt_d   = '0;
        end else if (accept && (dec_op == OpMthi)) begin
          hi_d = A;
        end else if (accept && (dec_op == OpMtlo)) begin
          lo_d = A;
        end
      end
      StCalc: begin
        cnt_d = cnt_q + CntW'(1);
        if (last_step) begin
          state_d = StFinish;
          done_d  = 1'b1;
          rw_d    = (op_q == OpMul);
        end
      end
      StFinish: begin
        state_d = StIdle;
        case (op_q)
          OpMadd, OpMaddu: {hi_d, lo_d} = {hi_q, lo_q} + p_fin;
          OpMsub, OpMsubu: {hi_d, lo_d} = {hi_q, lo_q} - p_fin;
          OpMult, OpMultu: {hi_d, lo_d} = p_fin;
          OpMul:           mul_result_d = p_fin[WIDTH-1:0];
          default:         ;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q      <= StIdle;
      op_q         <= OpNone;
      neg_q        <= 1'b0;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mul_result_q <= '0;
      done_q       <= 1'b0;
      rw_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_result_q <= mul_result_d;
      done_q       <= done_d;
      rw_q         <= rw_d;
    end
  end

  assign Busy        = (state_q != StIdle);
  assign Stall       = Start && Busy && (dec_op != OpNone);
  assign Done        = done_q;
  assign ResultWrite = rw_q;
  // Product is final throughout FINISH, so MUL's word is forwarded while ResultWrite is high.
  assign MulResult   = rw_q ? p_fin[WIDTH-1:0] : mul_result_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed vectors plus random ops against a 64-bit model.
module tb_mul_sequencer;

  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'h10, F_MTHI  = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18, F_MULTU = 6'h19;
  localparam logic [5:0] F_MADD  = 6'h00, F_MADDU = 6'h01, F_MUL  = 6'h02;
  localparam logic [5:0] F_MSUB  = 6'h04, F_MSUBU = 6'h05;

  logic          Clock = 1'b0;
  logic          nReset;
  logic          Start, Sp2;
  logic [5:0]    Func;
  logic [W-1:0]  A, B;
  logic          Busy, Stall, Done, ResultWrite;
  logic [W-1:0]  MulResult, HI, LO;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_hi = '0, m_lo = '0, m_mulres = '0;

  mul_sequencer #(.WIDTH(W)) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .Start      (Start),
    .Sp2        (Sp2),
    .Func       (Func),
    .A          (A),
    .B          (B),
    .Busy       (Busy),
    .Stall      (Stall),
    .Done       (Done),
    .ResultWrite(ResultWrite),
    .MulResult  (MulResult),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic op_signed(input logic sp2, input logic [5:0] f);
    return sp2 ? (f == F_MADD || f == F_MSUB || f == F_MUL) : (f == F_MULT);
  endfunction

  function automatic logic [63:0] product(input logic sp2, input logic [5:0] f,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    if (op_signed(sp2, f)) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Number of CALC cycles the sequencer should spend for this multiplier.
  function automatic int calc_cycles(input logic sp2, input logic [5:0] f, input logic [W-1:0] b);
    logic [W-1:0] mag;
    int n;
    mag = (op_signed(sp2, f) && b[W-1]) ? -b : b;
    n = W;
`ifdef MUL_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
`endif
    return n;
  endfunction

  task automatic model_apply(input logic sp2, input logic [5:0] f,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p, hl;
    p  = product(sp2, f, a, b);
    hl = {m_hi, m_lo};
    if (sp2 && f == F_MUL) m_mulres = p[W-1:0];
    else if (sp2 && (f == F_MADD || f == F_MADDU)) {m_hi, m_lo} = hl + p;
    else if (sp2 && (f == F_MSUB || f == F_MSUBU)) {m_hi, m_lo} = hl - p;
    else {m_hi, m_lo} = p;
  endtask

  task automatic run_long(input logic sp2, input logic [5:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    int k, exp_k;
    logic is_mul;
    logic [W-1:0] hi0, lo0;
    logic [63:0] p;
    is_mul = sp2 && (f == F_MUL);
    exp_k  = calc_cycles(sp2, f, b) + 1;
    p      = product(sp2, f, a, b);
    hi0    = m_hi;
    lo0    = m_lo;
    Start = 1'b1; Sp2 = sp2; Func = f; A = a; B = b;
    tick();
    Start = 1'b0; A = $urandom; B = $urandom; Func = 6'($urandom);
    checks++;
    if (Busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_rise: got %b want 1", name, Busy);
    end
    k = 1;
    while (Done !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    checks++;
    if (k !== exp_k) begin
      errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, k, exp_k);
    end
    checks++;
    if (ResultWrite !== is_mul) begin
      errors++; $display("FAIL %s result_write: got %b want %b", name, ResultWrite, is_mul);
    end
    if (is_mul) begin
      checks++;
      if (MulResult !== p[W-1:0]) begin
        errors++; $display("FAIL %s mul_result: got %h want %h", name, MulResult, p[W-1:0]);
      end
    end
    tick();
    model_apply(sp2, f, a, b);
    checks++;
    if (HI !== m_hi || LO !== m_lo) begin
      errors++; $display("FAIL %s hilo: got %h_%h want %h_%h", name, HI, LO, m_hi, m_lo);
    end
    if (is_mul) begin
      checks++;
      if (HI !== hi0 || LO !== lo0) begin
        errors++; $display("FAIL %s mul_hilo_kept: got %h_%h want %h_%h", name, HI, LO, hi0, lo0);
      end
    end
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || ResultWrite !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_flags: got busy=%b done=%b rw=%b want 0 0 0", name, Busy, Done,
               ResultWrite);
    end
  endtask

  task automatic move_to(input logic [5:0] f, input logic [W-1:0] a);
    Start = 1'b1; Sp2 = 1'b0; Func = f; A = a;
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL move_stall: got %b want 0", Stall);
    end
    tick();
    Start = 1'b0;
    if (f == F_MTHI) m_hi = a; else m_lo = a;
    checks++;
    if (HI !== m_hi || LO !== m_lo || Busy !== 1'b0) begin
      errors++;
      $display("FAIL move_hilo: got %h_%h busy=%b want %h_%h busy=0", HI, LO, Busy, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0; Start = 1'b0; Sp2 = 1'b0; Func = '0; A = '0; B = '0;
    #12;
    checks++;
    if (Busy !== 1'b0 || Stall !== 1'b0 || Done !== 1'b0 || ResultWrite !== 1'b0 ||
        HI !== '0 || LO !== '0 || MulResult !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b stall=%b done=%b rw=%b hi=%h lo=%h mr=%h want all 0",
               Busy, Stall, Done, ResultWrite, HI, LO, MulResult);
    end
    tick();
    nReset = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    run_long(1'b0, F_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    checks++;
    if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++; $display("FAIL mult_neg_const: got %h_%h want ffffffff_ffffffeb", HI, LO);
    end
    run_long(1'b0, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    checks++;
    if ({HI, LO} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL multu_max_const: got %h_%h want fffffffe_00000001", HI, LO);
    end
    move_to(F_MTHI, 32'd0);
    move_to(F_MTLO, 32'd10);
    run_long(1'b1, F_MADD, 32'd2, 32'd3, "madd");
    checks++;
    if ({HI, LO} !== 64'd16) begin
      errors++; $display("FAIL madd_const: got %h_%h want 00000000_00000010", HI, LO);
    end
    run_long(1'b1, F_MSUB, 32'd5, 32'd4, "msub");
    checks++;
    if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL msub_const: got %h_%h want ffffffff_fffffffc", HI, LO);
    end
    run_long(1'b1, F_MUL, 32'd6, 32'd7, "mul");
    checks++;
    if (MulResult !== 32'd42) begin
      errors++; $display("FAIL mul_const: got %0d want 42", MulResult);
    end
    run_long(1'b0, F_MULTU, 32'd5, 32'd3, "multu_small");
    run_long(1'b0, F_MULTU, 32'h1234_5678, 32'd0, "multu_zero");
  endtask

  task automatic test_unrecognised();
    Start = 1'b1; Sp2 = 1'b1; Func = 6'h3F; A = $urandom; B = $urandom;
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL unrec_stall: got %b want 0", Stall);
    end
    tick();
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
      errors++;
      $display("FAIL unrec_ignored: got busy=%b %h_%h want busy=0 %h_%h", Busy, HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] a, b;
    int k, stalls, exp_stalls;
    a = $urandom;
    b = $urandom | 32'h8000_0000;
    exp_stalls = calc_cycles(1'b0, F_MULTU, b) - 3;
    Start = 1'b1; Sp2 = 1'b0; Func = F_MULTU; A = a; B = b;
    tick();
    Start = 1'b0;
    repeat (4) tick();
    k = 4;
    stalls = 0;
    Start = 1'b1;
    while (Busy === 1'b1 && k < 200) begin
      // Early stalled presentations are MTHI with junk; they must never land in HI.
      Func = (k < 8) ? F_MTHI : F_MFLO;
      A = $urandom;
      #0;
      if (Stall === 1'b1) stalls++;
      tick();
      k++;
    end
    Func = F_MFLO;
    #0;
    model_apply(1'b0, F_MULTU, a, b);
    checks++;
    if (stalls !== exp_stalls) begin
      errors++; $display("FAIL stall_cycles: got %0d want %0d", stalls, exp_stalls);
    end
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL stall_release: got %b want 0", Stall);
    end
    checks++;
    if (HI !== m_hi || LO !== m_lo) begin
      errors++; $display("FAIL stall_hilo: got %h_%h want %h_%h", HI, LO, m_hi, m_lo);
    end
    tick();
    Start = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] fs[7];
    logic       s2[7];
    int sel;
    fs = '{F_MULT, F_MULTU, F_MADD, F_MADDU, F_MSUB, F_MSUBU, F_MUL};
    s2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 20; i++) begin
      sel = $urandom_range(0, 8);
      if (sel == 7) move_to(F_MTHI, $urandom);
      else if (sel == 8) move_to(F_MTLO, $urandom);
      else run_long(s2[sel], fs[sel], $urandom, $urandom >> $urandom_range(0, 31), "random");
    end
  endtask

  task automatic test_async_reset();
    move_to(F_MTHI, 32'hA5A5_0001);
    move_to(F_MTLO, 32'h5A5A_0002);
    Start = 1'b1; Sp2 = 1'b0; Func = F_MULTU; A = $urandom; B = 32'hFFFF_FFFF;
    tick();
    Start = 1'b0;
    repeat (10) tick();
    #2;
    nReset = 1'b0;
    #1;
    m_hi = '0; m_lo = '0; m_mulres = '0;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || HI !== '0 || LO !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b %h_%h want busy=0 done=0 0_0", Busy, Done,
               HI, LO);
    end
    tick();
    nReset = 1'b1;
    tick();
    checks++;
    if (Busy !== 1'b0) begin
      errors++; $display("FAIL async_reset_idle: got busy=%b want 0", Busy);
    end
    run_long(1'b0, F_MULT, 32'd9, 32'hFFFF_FFFE, "after_reset");
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_unrecognised();
    test_stall();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
